// File: rtl/knight_pkg.sv
// rtl/knight_pkg.sv - shared types for the knight-side receive path
// Provides the framer state type used by uart_cmd_framer.
package knight_pkg;

    typedef enum logic {
        FRM_IDLE = 1'b0,
        FRM_LOW  = 1'b1
    } frm_state_t;

endpackage : knight_pkg

// File: rtl/byte_timer.sv
// rtl/byte_timer.sv - saturating inter-byte timer with terminal-count flag
// Ports:
//   clk    in  system clock
//   rst_n  in  synchronous active-low reset
//   clr    in  synchronous clear to zero (wins over en)
//   en     in  count enable
//   tc     out count has reached TIMEOUT_CYC-1
module byte_timer #(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int W = $clog2(TIMEOUT_CYC);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] count;

    // Holds at LAST rather than wrapping, so tc stays asserted until cleared.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + W'(1);
        end
    end

    assign tc = (count == LAST);

endmodule : byte_timer

// File: rtl/uart_cmd_framer.sv
// rtl/uart_cmd_framer.sv - rebuilds 16-bit commands from a UART byte stream
// Ports:
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset
//   rx_rdy       in   UART byte available in rx_data
//   rx_data      in   received byte
//   clr_rx_rdy   out  combinational byte acknowledge to the UART
//   clr_cmd_rdy  in   consumer took cmd; clears cmd_rdy and overrun
//   cmd          out  assembled command {high, low}
//   cmd_rdy      out  cmd valid, held until clr_cmd_rdy
//   overrun      out  sticky: completion while cmd_rdy was still set
//   timeout_err  out  one-cycle pulse when a lone high byte is dropped
module uart_cmd_framer
    import knight_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    input  logic        clr_cmd_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic        overrun,
    output logic        timeout_err
);

    frm_state_t state;
    logic [7:0] hi_byte;
    logic       timer_tc;
    logic       complete;

    // Every byte is consumed in the cycle it is presented, whatever the state.
    assign clr_rx_rdy = rx_rdy & rst_n;
    assign complete   = (state == FRM_LOW) && rx_rdy;

    byte_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_byte_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   ((state == FRM_IDLE) && rx_rdy),
        .en    (state == FRM_LOW),
        .tc    (timer_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= FRM_IDLE;
            hi_byte     <= 8'h00;
            cmd         <= 16'h0000;
            cmd_rdy     <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;

            if (state == FRM_IDLE) begin
                if (rx_rdy) begin
                    hi_byte <= rx_data;
                    state   <= FRM_LOW;
                end
            end else begin
                // A low byte landing on the terminal cycle still completes.
                if (rx_rdy) begin
                    cmd   <= {hi_byte, rx_data};
                    state <= FRM_IDLE;
                end else if (timer_tc) begin
                    timeout_err <= 1'b1;
                    state       <= FRM_IDLE;
                end
            end

            if (complete) begin
                cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy) begin
                cmd_rdy <= 1'b0;
            end

            if (complete && cmd_rdy && !clr_cmd_rdy) begin
                overrun <= 1'b1;
            end else if (clr_cmd_rdy) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule : uart_cmd_framer

// File: tb/tb_uart_cmd_framer.sv
// tb/tb_uart_cmd_framer.sv - self-checking bench for uart_cmd_framer
module tb_uart_cmd_framer;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        clr_rx_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        overrun;
    logic        timeout_err;

    uart_cmd_framer #(.TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_rdy      (rx_rdy),
        .rx_data     (rx_data),
        .clr_rx_rdy  (clr_rx_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: a pending high byte and how many cycles it has waited.
    logic        m_pend = 1'b0;
    logic [7:0]  m_hi = 8'h00;
    int          m_age = 0;
    logic [15:0] m_cmd = 16'h0000;
    logic        m_rdy = 1'b0;
    logic        m_ovr = 1'b0;
    logic        m_to = 1'b0;
    int          n_ack = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic rx, input logic [7:0] d, input logic clr);
        logic done;
        logic was_rdy;
        done = 1'b0;
        was_rdy = m_rdy;
        if (!rst_n) begin
            m_pend = 1'b0; m_hi = 8'h00; m_age = 0;
            m_cmd = 16'h0000; m_rdy = 1'b0; m_ovr = 1'b0; m_to = 1'b0;
            return;
        end
        m_to = 1'b0;
        if (m_pend) begin
            m_age++;
            if (rx) begin
                done = 1'b1;
                m_cmd = {m_hi, d};
                m_pend = 1'b0;
            end else if (m_age >= TO) begin
                m_to = 1'b1;
                m_pend = 1'b0;
            end
        end else if (rx) begin
            m_pend = 1'b1;
            m_hi = d;
            m_age = 0;
        end
        if (clr) begin
            m_rdy = 1'b0;
            m_ovr = 1'b0;
        end
        if (done) begin
            if (was_rdy && !clr) m_ovr = 1'b1;
            m_rdy = 1'b1;
        end
    endtask

    // One clock: drive inputs, check the ack, clock, then check registered outputs.
    task automatic cyc(input logic rx, input logic [7:0] d, input logic clr);
        rx_rdy = rx;
        rx_data = d;
        clr_cmd_rdy = clr;
        #1;
        chk("clr_rx_rdy", {15'd0, clr_rx_rdy}, {15'd0, rx & rst_n});
        if (clr_rx_rdy) n_ack++;
        @(posedge clk);
        model_edge(rx, d, clr);
        #1;
        chk("cmd", cmd, m_cmd);
        chk("cmd_rdy", {15'd0, cmd_rdy}, {15'd0, m_rdy});
        chk("overrun", {15'd0, overrun}, {15'd0, m_ovr});
        chk("timeout_err", {15'd0, timeout_err}, {15'd0, m_to});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        // Reset, with rx_rdy asserted so the ack must be masked.
        rst_n = 1'b0;
        cyc(1'b1, 8'hEE, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("reset_cmd", cmd, 16'h0000);
        chk("reset_rdy", {15'd0, cmd_rdy}, 16'd0);
        rst_n = 1'b1;
        idle(2);

        // 1: A5 then 3C, 20 cycles apart.
        n_ack = 0;
        cyc(1'b1, 8'hA5, 1'b0);
        idle(19);
        cyc(1'b1, 8'h3C, 1'b0);
        chk("t1_cmd", cmd, 16'hA53C);
        chk("t1_rdy", {15'd0, cmd_rdy}, 16'd1);
        chk("t1_acks", 16'(n_ack), 16'd2);
        cyc(1'b0, 8'h00, 1'b1);

        // 2: lone high byte times out after exactly TO cycles.
        cyc(1'b1, 8'h12, 1'b0);
        idle(TO - 1);
        chk("t2_no_early_to", {15'd0, timeout_err}, 16'd0);
        idle(1);
        chk("t2_to_pulse", {15'd0, timeout_err}, 16'd1);
        chk("t2_rdy", {15'd0, cmd_rdy}, 16'd0);
        idle(1);
        chk("t2_to_one_cycle", {15'd0, timeout_err}, 16'd0);
        cyc(1'b1, 8'h34, 1'b0);
        cyc(1'b1, 8'h56, 1'b0);
        chk("t2_cmd", cmd, 16'h3456);
        cyc(1'b0, 8'h00, 1'b1);

        // 3: overrun on a second unacknowledged command.
        cyc(1'b1, 8'h11, 1'b0);
        cyc(1'b1, 8'h11, 1'b0);
        cyc(1'b1, 8'h22, 1'b0);
        cyc(1'b1, 8'h22, 1'b0);
        chk("t3_cmd", cmd, 16'h2222);
        chk("t3_ovr", {15'd0, overrun}, 16'd1);
        cyc(1'b0, 8'h00, 1'b1);
        chk("t3_clr_rdy", {15'd0, cmd_rdy}, 16'd0);
        chk("t3_clr_ovr", {15'd0, overrun}, 16'd0);

        // 4: clear coinciding with completion while cmd_rdy is set.
        cyc(1'b1, 8'h55, 1'b0);
        cyc(1'b1, 8'h55, 1'b0);
        cyc(1'b1, 8'h77, 1'b0);
        cyc(1'b1, 8'h88, 1'b1);
        chk("t4_rdy", {15'd0, cmd_rdy}, 16'd1);
        chk("t4_ovr", {15'd0, overrun}, 16'd0);
        chk("t4_cmd", cmd, 16'h7788);
        cyc(1'b0, 8'h00, 1'b1);

        // 5: reset mid-frame discards the high byte.
        cyc(1'b1, 8'hFF, 1'b0);
        rst_n = 1'b0;
        cyc(1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
        cyc(1'b1, 8'h00, 1'b0);
        cyc(1'b1, 8'h01, 1'b0);
        chk("t5_cmd", cmd, 16'h0001);
        idle(TO + 10);
        cyc(1'b0, 8'h00, 1'b1);

        // 6: low byte on the last permitted cycle is accepted.
        cyc(1'b1, 8'hAB, 1'b0);
        idle(TO - 1);
        cyc(1'b1, 8'hCD, 1'b0);
        chk("t6_cmd", cmd, 16'hABCD);
        chk("t6_no_to", {15'd0, timeout_err}, 16'd0);
        idle(2);
        cyc(1'b0, 8'h00, 1'b1);

        // Random traffic: dense, then sparse enough to provoke timeouts.
        for (int ph = 0; ph < 3; ph++) begin
            int pct;
            pct = (ph == 0) ? 60 : (ph == 1) ? 2 : 25;
            for (int i = 0; i < 1200; i++) begin
                logic r;
                logic c;
                r = ($urandom_range(0, 99) < pct);
                c = ($urandom_range(0, 99) < 15);
                if ($urandom_range(0, 999) == 0) rst_n = 1'b0;
                else rst_n = 1'b1;
                cyc(r, 8'($urandom), c);
            end
        end
        rst_n = 1'b1;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_uart_cmd_framer
